i2s_tx_channel: RTL and testbench
=================================

Name: i2s_tx_channel

Overview:
- Serialises 32-bit audio words from the uDMA TX FIFO onto one or two I2S data lines.
- Acts as a word-select slave: it uses i2s_ws_i edges for frame alignment and runs entirely in the sck_i domain.
- It is the transmit counterpart of the I2S RX channel and sits between the TX FIFO and the I2S pads.
- Shadow registers decouple FIFO handshakes from the bit timing. An underrun raises a one-cycle error pulse.

Parameters:
- none. Word width is fixed at 32 bits; the 5-bit cfg_wlen_i selects 1..32 bits per word.

Ports:
- sck_i  input  1  serial clock; all state changes on its rising edge
- rst_i  input  1  reset, asynchronous, active-high
- i2s_ws_i  input  1  word select from the external master or clock generator
- i2s_ch0_o  output  1  serial data, channel 0
- i2s_ch1_o  output  1  serial data, channel 1 (driven only in 2-channel mode)
- fifo_data_i  input  32  word from the TX FIFO, right-aligned (bits [wlen:0] used)
- fifo_data_valid_i  input  1  FIFO word valid
- fifo_data_ready_o  output  1  block accepts fifo_data_i this cycle
- fifo_err_o  output  1  underrun pulse
- cfg_en_i  input  1  channel enable
- cfg_2ch_i  input  1  1 = two data lines, 0 = ch0 only
- cfg_wlen_i  input  5  bits per word minus 1
- cfg_lsb_first_i  input  1  1 = LSB first, 0 = MSB first

Behaviour:
- Reset: all registers clear; i2s_ch0_o=0, i2s_ch1_o=0, fifo_data_ready_o=0, fifo_err_o=0, counter=0, shadow slots empty.
- Edge detect: ws_edge = i2s_ws_i XOR ws_old; ws_old is registered every cycle.
- Start/stop:
  - On ws_edge, started <= cfg_en_i.
  - started_dly <= started every cycle.
  - Start and stop therefore take effect only at a frame boundary.
- Arm cycle (started=1, started_dly=0):
  - ch0 shift register loads from shadow0.
  - ch1 shift register loads from shadow1 (only if cfg_2ch_i).
  - Loaded slots are marked empty.
- Output bit is taken straight from the shift register:
  - MSB-first: sr[cfg_wlen_i].
  - LSB-first: sr[0].
  - The first bit is therefore valid after the 2nd rising edge following the ws change (one-bit I2S delay).
- While started_dly=1:
  - Bit counter increments each cycle.
  - word_done = (count == cfg_wlen_i); on word_done the counter goes to 0.
  - Not word_done: shift left (MSB-first) or shift right with zero fill (LSB-first).
  - word_done: reload the shift registers from the shadow slots, as in the arm cycle. Each word thus lasts cfg_wlen_i+1 cycles.
- Underrun:
  - At an arm or word_done load, if a required slot is empty (shadow0, or shadow1 when cfg_2ch_i), that register loads 0.
  - fifo_err_o pulses high for exactly that one cycle; it is the OR of the two channels, never two pulses.
- Shadow fill:
  - target = shadow0 if it is empty, else shadow1 (only when cfg_2ch_i).
  - fifo_data_ready_o = cfg_en_i AND the target slot is empty.
  - On valid & ready, the target slot takes fifo_data_i and is marked full.
  - A fill and a load in the same cycle: the load consumes the old slot content and the slot ends full with the new word. An empty slot cannot bypass to the shift register; the data is held for the next load.
  - Words therefore alternate ch0, ch1 in 2-channel mode.
- Mono mode: i2s_ch1_o is held 0 and shadow1 is never filled.
- Stop (started_dly=0):
  - Counter is held at 0; outputs are 0.
  - If cfg_en_i=0, both shadow slots are flushed (marked empty).
  - A word in flight when started drops completes no further shifting: outputs go to 0 the cycle after started_dly falls.
- Config changes while started are unsupported: software changes cfg_* only with cfg_en_i=0 and the channel stopped.
- rst_i mid-operation: immediate clear to the reset values; resume requires a new ws edge with cfg_en_i=1.

Decomposition:
- Shared package i2s_pkg:
  - WORD_W=32 and WLEN_W=5 constants.
  - Typedef i2s_word_t (logic [31:0]).
- Sub-module i2s_tx_shifter, instantiated per channel. It owns the shift register, the MSB/LSB output select and the load/shift control.
- The top level owns ws detection, start logic, the counter, the shadow slots and the FIFO handshake.

Test Plan:
- Mono, MSB-first, wlen=15: FIFO holds 0x0000A5C3, ws toggles every 16 cycles, en=1 -> ch0 emits 1010010111000011 from the 2nd edge after the ws edge; no fifo_err_o.
- Mono, LSB-first, wlen=7: word 0x000000B1 -> ch0 emits 1,0,0,0,1,1,0,1.
- 2ch, wlen=31: FIFO holds 0x12345678 then 0x9ABCDEF0 -> ch0 serialises 0x12345678 and ch1 serialises 0x9ABCDEF0 in the same 32 cycles; ready deasserts once both slots are full.
- Underrun: a single word is supplied, then valid=0 -> the second word period is all zeros and fifo_err_o is high for exactly 1 cycle, at that word's load edge.
- Enable timing: cfg_en_i rises mid-frame -> outputs stay 0 and ready stays high until the next ws edge; disable mid-stream -> shifting stops at the next ws edge and the slots are flushed.
- Async reset asserted during 2ch streaming -> outputs, ready and err go to 0 at once; after release, no data until the next ws edge.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmit channel.
// Latency: n/a (types only).
// Backpressure: n/a.
package i2s_pkg;

    localparam int WORD_W = 32;
    localparam int WLEN_W = 5;

    typedef logic [WORD_W-1:0] i2s_word_t;

    // One staging slot between the FIFO handshake and a channel shift register.
    typedef struct packed {
        logic      full;
        i2s_word_t dat;
    } shadow_t;

endpackage

// File: rtl/i2s_tx_shifter.sv
// Per-channel serialiser: holds one word and presents one bit per sck_i cycle.
// Latency: loaded word's first bit appears on sdo the cycle after load.
// Backpressure: none; load/shift/clr are driven by the channel controller.
//
// Ports:
//   sck_i, rst_i  serial clock, async active-high reset
//   load          capture load_dat (highest priority)
//   shift         advance one bit (left for MSB-first, right for LSB-first)
//   clr           zero the register (channel idle)
//   load_dat      word to load, right-aligned
//   wlen          bits per word minus 1 (selects MSB position)
//   lsb_first     1 = LSB first, 0 = MSB first
//   sdo           serial data out
module i2s_tx_shifter
    import i2s_pkg::*;
(
    input  logic              sck_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic              shift,
    input  logic              clr,
    input  i2s_word_t         load_dat,
    input  logic [WLEN_W-1:0] wlen,
    input  logic              lsb_first,
    output logic              sdo
);

    i2s_word_t sr;

    always_ff @(posedge sck_i or posedge rst_i) begin
        if (rst_i) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_dat;
        end else if (shift) begin
            // Zero fill on both directions so bits beyond the word never leak out.
            sr <= lsb_first ? (sr >> 1) : (sr << 1);
        end else if (clr) begin
            sr <= '0;
        end
    end

    // The output bit is taken straight from the register; MSB position
    // follows the configured word length.
    assign sdo = lsb_first ? sr[0] : sr[wlen];

endmodule

// File: rtl/i2s_tx_channel.sv
// I2S transmit channel (ws slave): serialises FIFO words onto one or two data lines.
// Latency: first bit is valid after the 2nd sck_i rising edge following a ws change.
// Backpressure: fifo_data_ready_o only while enabled and the target shadow slot is empty.
//
// Ports:
//   sck_i, rst_i         serial clock, async active-high reset
//   i2s_ws_i             word select from the external master
//   i2s_ch0_o/ch1_o      serial data lines (ch1 only in 2-channel mode)
//   fifo_data_*          TX FIFO word / valid / ready
//   fifo_err_o           one-cycle underrun pulse
//   cfg_*                enable, 2-channel, word length-1, LSB-first
module i2s_tx_channel
    import i2s_pkg::*;
(
    input  logic              sck_i,
    input  logic              rst_i,
    input  logic              i2s_ws_i,
    output logic              i2s_ch0_o,
    output logic              i2s_ch1_o,
    input  i2s_word_t         fifo_data_i,
    input  logic              fifo_data_valid_i,
    output logic              fifo_data_ready_o,
    output logic              fifo_err_o,
    input  logic              cfg_en_i,
    input  logic              cfg_2ch_i,
    input  logic [WLEN_W-1:0] cfg_wlen_i,
    input  logic              cfg_lsb_first_i
);

    logic              ws_old;
    logic              started;
    logic              started_dly;
    logic              rst_done;
    logic              fifo_err;
    logic [WLEN_W-1:0] count;
    shadow_t           shadow0;
    shadow_t           shadow1;

    logic ws_edge;
    logic arm;
    logic word_done;
    logic load;
    logic underrun;
    logic fill0;
    logic fill1;
    logic accept;
    logic flush;

    assign ws_edge   = i2s_ws_i ^ ws_old;
    assign arm       = started & ~started_dly;
    assign word_done = started_dly & (count == cfg_wlen_i);
    assign load      = arm | word_done;

    // A single pulse covers a missing word on either channel.
    assign underrun  = load & (~shadow0.full | (cfg_2ch_i & ~shadow1.full));

    // Fill target: shadow0 first, then shadow1 in 2-channel mode, so FIFO
    // words alternate ch0, ch1.
    assign fill0     = ~shadow0.full;
    assign fill1     = shadow0.full & cfg_2ch_i & ~shadow1.full;

    // rst_done keeps ready low while reset is asserted, even with cfg_en_i high.
    assign fifo_data_ready_o = cfg_en_i & rst_done & (fill0 | fill1);
    assign accept            = fifo_data_valid_i & fifo_data_ready_o;
    assign flush             = ~started_dly & ~cfg_en_i;
    assign fifo_err_o        = fifo_err;

    // Frame alignment, start/stop and bit counter.
    always_ff @(posedge sck_i or posedge rst_i) begin
        if (rst_i) begin
            ws_old      <= 1'b0;
            started     <= 1'b0;
            started_dly <= 1'b0;
            rst_done    <= 1'b0;
            fifo_err    <= 1'b0;
            count       <= '0;
        end else begin
            ws_old      <= i2s_ws_i;
            rst_done    <= 1'b1;
            started_dly <= started;
            fifo_err    <= underrun;
            // Enable is only sampled at a frame boundary.
            if (ws_edge) begin
                started <= cfg_en_i;
            end
            if (!started_dly || word_done) begin
                count <= '0;
            end else begin
                count <= count + WLEN_W'(1);
            end
        end
    end

    // Shadow slots. A same-cycle load reads the old content (register read),
    // so a concurrent fill leaves the slot full with the new word; an empty
    // slot never bypasses to the shift register.
    always_ff @(posedge sck_i or posedge rst_i) begin
        if (rst_i) begin
            shadow0 <= '0;
            shadow1 <= '0;
        end else if (flush) begin
            shadow0.full <= 1'b0;
            shadow1.full <= 1'b0;
        end else begin
            if (accept && fill0) begin
                shadow0 <= '{full: 1'b1, dat: fifo_data_i};
            end else if (load) begin
                shadow0.full <= 1'b0;
            end
            if (accept && fill1) begin
                shadow1 <= '{full: 1'b1, dat: fifo_data_i};
            end else if (load && cfg_2ch_i) begin
                shadow1.full <= 1'b0;
            end
        end
    end

    i2s_tx_shifter u_sh0 (
        .sck_i     (sck_i),
        .rst_i     (rst_i),
        .load      (load),
        .shift     (started_dly & ~word_done),
        .clr       (~started_dly),
        .load_dat  (shadow0.full ? shadow0.dat : '0),
        .wlen      (cfg_wlen_i),
        .lsb_first (cfg_lsb_first_i),
        .sdo       (i2s_ch0_o)
    );

    // In mono mode ch1 is never loaded and is held cleared.
    i2s_tx_shifter u_sh1 (
        .sck_i     (sck_i),
        .rst_i     (rst_i),
        .load      (load & cfg_2ch_i),
        .shift     (started_dly & ~word_done & cfg_2ch_i),
        .clr       (~started_dly | ~cfg_2ch_i),
        .load_dat  (shadow1.full ? shadow1.dat : '0),
        .wlen      (cfg_wlen_i),
        .lsb_first (cfg_lsb_first_i),
        .sdo       (i2s_ch1_o)
    );

endmodule

// File: tb/tb_i2s_tx_channel.sv
module tb_i2s_tx_channel;
    import i2s_pkg::*;

    logic        sck_i = 1'b0;
    logic        rst_i;
    logic        i2s_ws_i;
    logic        i2s_ch0_o;
    logic        i2s_ch1_o;
    i2s_word_t   fifo_data_i;
    logic        fifo_data_valid_i;
    logic        fifo_data_ready_o;
    logic        fifo_err_o;
    logic        cfg_en_i;
    logic        cfg_2ch_i;
    logic [4:0]  cfg_wlen_i;
    logic        cfg_lsb_first_i;

    i2s_tx_channel dut (
        .sck_i             (sck_i),
        .rst_i             (rst_i),
        .i2s_ws_i          (i2s_ws_i),
        .i2s_ch0_o         (i2s_ch0_o),
        .i2s_ch1_o         (i2s_ch1_o),
        .fifo_data_i       (fifo_data_i),
        .fifo_data_valid_i (fifo_data_valid_i),
        .fifo_data_ready_o (fifo_data_ready_o),
        .fifo_err_o        (fifo_err_o),
        .cfg_en_i          (cfg_en_i),
        .cfg_2ch_i         (cfg_2ch_i),
        .cfg_wlen_i        (cfg_wlen_i),
        .cfg_lsb_first_i   (cfg_lsb_first_i)
    );

    always #5 sck_i = ~sck_i;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          chk   = 1'b0;
    bit          q0[$];
    bit          q1[$];
    bit          qe[$];
    logic [31:0] fq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            q0.push_back(1'b0);
            q1.push_back(1'b0);
            qe.push_back(1'b0);
        end
    endtask

    // Expected serial stream for one word period, using the bench's own config.
    task automatic push_word(input logic [31:0] w0, input bit has0,
                             input logic [31:0] w1, input bit has1);
        int wl;
        int idx;
        wl = int'(cfg_wlen_i);
        for (int i = 0; i <= wl; i++) begin
            idx = cfg_lsb_first_i ? i : wl - i;
            q0.push_back(has0 ? w0[idx] : 1'b0);
            q1.push_back((cfg_2ch_i && has1) ? w1[idx] : 1'b0);
            qe.push_back(i == 0 && (!has0 || (cfg_2ch_i && !has1)));
        end
    endtask

    // One sck_i cycle: drive FIFO from the bench queue, then compare outputs
    // against the scoreboard #1 after the rising edge.
    task automatic step();
        bit acc;
        bit e0;
        bit e1;
        bit ee;
        fifo_data_valid_i = (fq.size() != 0);
        fifo_data_i       = (fq.size() != 0) ? fq[0] : '0;
        #1;
        acc = fifo_data_valid_i && fifo_data_ready_o;
        @(posedge sck_i);
        #1;
        cyc++;
        if (acc) void'(fq.pop_front());
        if (chk) begin
            e0 = 1'b0; e1 = 1'b0; ee = 1'b0;
            if (q0.size() != 0) e0 = q0.pop_front();
            if (q1.size() != 0) e1 = q1.pop_front();
            if (qe.size() != 0) ee = qe.pop_front();
            check($sformatf("ch0@%0d", cyc), 32'(i2s_ch0_o), 32'(e0));
            check($sformatf("ch1@%0d", cyc), 32'(i2s_ch1_o), 32'(e1));
            check($sformatf("err@%0d", cyc), 32'(fifo_err_o), 32'(ee));
        end
    endtask

    task automatic start();
        i2s_ws_i = ~i2s_ws_i;
        chk = 1'b1;
    endtask

    task automatic stop_chan(input string tag);
        cfg_en_i = 1'b0;
        i2s_ws_i = ~i2s_ws_i;
        chk = 1'b0;
        repeat (4) step();
        q0.delete(); q1.delete(); qe.delete();
        check({tag, "_ch0"}, 32'(i2s_ch0_o), 32'd0);
        check({tag, "_ch1"}, 32'(i2s_ch1_o), 32'd0);
        check({tag, "_err"}, 32'(fifo_err_o), 32'd0);
        check({tag, "_rdy"}, 32'(fifo_data_ready_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; i2s_ws_i = 1'b0; fifo_data_i = '0; fifo_data_valid_i = 1'b0;
        cfg_en_i = 1'b0; cfg_2ch_i = 1'b0; cfg_wlen_i = 5'd0; cfg_lsb_first_i = 1'b0;
        repeat (3) @(posedge sck_i);
        #1;
        check("rst_ch0", 32'(i2s_ch0_o), 32'd0);
        check("rst_ch1", 32'(i2s_ch1_o), 32'd0);
        check("rst_rdy", 32'(fifo_data_ready_o), 32'd0);
        check("rst_err", 32'(fifo_err_o), 32'd0);
        rst_i = 1'b0;

        // Mono, MSB-first, 16-bit; enable mid-frame waits for a ws edge.
        cfg_2ch_i = 1'b0; cfg_wlen_i = 5'd15; cfg_lsb_first_i = 1'b0; cfg_en_i = 1'b1;
        repeat (3) step();
        check("en_idle_rdy", 32'(fifo_data_ready_o), 32'd1);
        check("en_idle_ch0", 32'(i2s_ch0_o), 32'd0);
        fq.push_back(32'h0000A5C3);
        repeat (2) step();
        check("mono_full_rdy", 32'(fifo_data_ready_o), 32'd0);
        push_idle(1);
        push_word(32'h0000A5C3, 1'b1, '0, 1'b0);
        start();
        repeat (17) step();
        stop_chan("stop1");

        // Mono, LSB-first, 8-bit, single word then underrun period.
        cfg_wlen_i = 5'd7; cfg_lsb_first_i = 1'b1; cfg_en_i = 1'b1;
        fq.push_back(32'h000000B1);
        repeat (2) step();
        push_idle(1);
        push_word(32'h000000B1, 1'b1, '0, 1'b0);
        push_word('0, 1'b0, '0, 1'b0);
        start();
        repeat (17) step();
        stop_chan("stop2");

        // Two channels, 32-bit; disable mid-stream, word still completes.
        cfg_2ch_i = 1'b1; cfg_wlen_i = 5'd31; cfg_lsb_first_i = 1'b0; cfg_en_i = 1'b1;
        fq.push_back(32'h12345678);
        fq.push_back(32'h9ABCDEF0);
        step();
        check("2ch_one_rdy", 32'(fifo_data_ready_o), 32'd1);
        step();
        check("2ch_both_rdy", 32'(fifo_data_ready_o), 32'd0);
        push_idle(1);
        push_word(32'h12345678, 1'b1, 32'h9ABCDEF0, 1'b1);
        start();
        repeat (20) step();
        cfg_en_i = 1'b0;
        repeat (13) step();
        stop_chan("stop3");

        // Flush while stopped: a filled slot is discarded when enable drops.
        cfg_2ch_i = 1'b0; cfg_wlen_i = 5'd7; cfg_lsb_first_i = 1'b0; cfg_en_i = 1'b1;
        fq.push_back(32'h000000FF);
        repeat (2) step();
        check("flush_pre_rdy", 32'(fifo_data_ready_o), 32'd0);
        cfg_en_i = 1'b0;
        step();
        cfg_en_i = 1'b1;
        step();
        check("flush_post_rdy", 32'(fifo_data_ready_o), 32'd1);
        push_idle(1);
        push_word('0, 1'b0, '0, 1'b0);
        start();
        repeat (9) step();
        stop_chan("stop4");

        // Async reset in the middle of 2-channel streaming.
        cfg_2ch_i = 1'b1; cfg_wlen_i = 5'd31; cfg_lsb_first_i = 1'b0; cfg_en_i = 1'b1;
        fq.push_back(32'hFFFFA5C3);
        fq.push_back(32'hFF801234);
        repeat (2) step();
        push_idle(1);
        push_word(32'hFFFFA5C3, 1'b1, 32'hFF801234, 1'b1);
        start();
        repeat (10) step();
        chk = 1'b0;
        q0.delete(); q1.delete(); qe.delete();
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_ch0", 32'(i2s_ch0_o), 32'd0);
        check("arst_ch1", 32'(i2s_ch1_o), 32'd0);
        check("arst_rdy", 32'(fifo_data_ready_o), 32'd0);
        check("arst_err", 32'(fifo_err_o), 32'd0);
        i2s_ws_i = 1'b0;
        @(posedge sck_i);
        #1;
        rst_i = 1'b0;
        fq.push_back(32'h0F0F00FF);
        fq.push_back(32'h80000001);
        push_idle(6);
        chk = 1'b1;
        repeat (6) step();
        push_idle(1);
        push_word(32'h0F0F00FF, 1'b1, 32'h80000001, 1'b1);
        start();
        repeat (33) step();
        stop_chan("stop5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
